// File: rtl/atm_keypad_frontend_if.sv
// Keypad-to-controller signal bundle: raw scanner inputs in, debounced
// digit/amount handshakes out. The slave side is the keypad front end.
interface atm_keypad_frontend_if;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic        MODO_MONTO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [31:0] MONTO_PARCIAL;
    logic [3:0]  DIGITOS_CNT;
    logic        ERROR_TECLA;

    modport master (
        output KEY_VALID, KEY_CODE, MODO_MONTO,
        input  DIGITO, DIGITO_STB, MONTO, MONTO_STB,
               MONTO_PARCIAL, DIGITOS_CNT, ERROR_TECLA
    );

    modport slave (
        input  KEY_VALID, KEY_CODE, MODO_MONTO,
        output DIGITO, DIGITO_STB, MONTO, MONTO_STB,
               MONTO_PARCIAL, DIGITOS_CNT, ERROR_TECLA
    );
endinterface

// File: rtl/atm_keypad_frontend.sv
// Debounces raw keypad presses and turns accepted keys into PIN digit
// strobes or a decimal amount accumulated to 32-bit binary.
module atm_keypad_frontend #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int MAX_MONTO_DIGITS = 9
) (
    input  logic                 CLK,
    input  logic                 RESET,
    atm_keypad_frontend_if.slave kp
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES);
    localparam logic [3:0] MAX_DIG   = 4'(MAX_MONTO_DIGITS);
    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        accept;
    logic        modo_q;
    logic        mode_chg;
    logic        is_digit;
    logic [31:0] acc_x10;
    logic [31:0] acc_q, acc_d;
    logic [31:0] monto_q, monto_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [3:0]  digito_q, digito_d;
    logic        dstb_q, dstb_d;
    logic        mstb_q, mstb_d;
    logic        err_q, err_d;

    // cnt_q holds how many consecutive stable samples have been seen so far
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (kp.KEY_VALID) begin
                    state_d = PRESS_DB;
                    code_d  = kp.KEY_CODE;
                    cnt_d   = 8'd1;
                end
            end
            PRESS_DB: begin
                if (cnt_q == DB_LAST) begin
                    accept  = 1'b1;
                    state_d = HELD;
                end else if (!kp.KEY_VALID) begin
                    state_d = IDLE;
                end else if (kp.KEY_CODE != code_q) begin
                    code_d = kp.KEY_CODE;
                    cnt_d  = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!kp.KEY_VALID) begin
                    state_d = REL_DB;
                    cnt_d   = 8'd1;
                end
            end
            REL_DB: begin
                if (kp.KEY_VALID) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mode_chg = kp.MODO_MONTO != modo_q;
    assign is_digit = code_q <= 4'd9;
    assign acc_x10  = (acc_q << 3) + (acc_q << 1) + {28'd0, code_q};

    // A mode change wipes the amount and swallows any key accepted alongside it
    always_comb begin
        acc_d    = acc_q;
        dcnt_d   = dcnt_q;
        monto_d  = monto_q;
        digito_d = digito_q;
        dstb_d   = 1'b0;
        mstb_d   = 1'b0;
        err_d    = 1'b0;
        if (mode_chg) begin
            acc_d  = '0;
            dcnt_d = '0;
        end else if (accept) begin
            if (!kp.MODO_MONTO) begin
                if (is_digit) begin
                    digito_d = code_q;
                    dstb_d   = 1'b1;
                end
            end else if (is_digit) begin
                if (dcnt_q < MAX_DIG) begin
                    acc_d  = acc_x10;
                    dcnt_d = dcnt_q + 4'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (code_q == KEY_CLEAR) begin
                acc_d  = '0;
                dcnt_d = '0;
            end else if (code_q == KEY_ENTER) begin
                if (dcnt_q != 4'd0) begin
                    monto_d = acc_q;
                    mstb_d  = 1'b1;
                    acc_d   = '0;
                    dcnt_d  = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            modo_q   <= 1'b0;
            acc_q    <= '0;
            monto_q  <= '0;
            dcnt_q   <= '0;
            digito_q <= '0;
            dstb_q   <= 1'b0;
            mstb_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            modo_q   <= kp.MODO_MONTO;
            acc_q    <= acc_d;
            monto_q  <= monto_d;
            dcnt_q   <= dcnt_d;
            digito_q <= digito_d;
            dstb_q   <= dstb_d;
            mstb_q   <= mstb_d;
            err_q    <= err_d;
        end
    end

    assign kp.DIGITO        = digito_q;
    assign kp.DIGITO_STB    = dstb_q;
    assign kp.MONTO         = monto_q;
    assign kp.MONTO_STB     = mstb_q;
    assign kp.MONTO_PARCIAL = acc_q;
    assign kp.DIGITOS_CNT   = dcnt_q;
    assign kp.ERROR_TECLA   = err_q;
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed and randomized key sequences checked against a transaction-level
// model of PIN digits, amount accumulation, ENTER/CLEAR and mode changes.
module tb_atm_keypad_frontend;
    localparam int D    = 4;
    localparam int MAXD = 9;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   errors = 0;
    int   checks = 0;

    atm_keypad_frontend_if kp();

    atm_keypad_frontend #(
        .DEBOUNCE_CYCLES (D),
        .MAX_MONTO_DIGITS(MAXD)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .kp   (kp)
    );

    always #5 CLK = ~CLK;

    // Model state: amount as a plain number, digit count, last results
    logic [31:0] m_acc    = '0;
    logic [31:0] m_monto  = '0;
    int          m_cnt    = 0;
    logic [3:0]  m_digito = '0;
    logic        m_modo   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digito"}, 32'(kp.DIGITO), 32'd0);
        check({tag, "_digito_stb"}, 32'(kp.DIGITO_STB), 32'd0);
        check({tag, "_monto"}, kp.MONTO, 32'd0);
        check({tag, "_monto_stb"}, 32'(kp.MONTO_STB), 32'd0);
        check({tag, "_parcial"}, kp.MONTO_PARCIAL, 32'd0);
        check({tag, "_cnt"}, 32'(kp.DIGITOS_CNT), 32'd0);
        check({tag, "_err"}, 32'(kp.ERROR_TECLA), 32'd0);
    endtask

    task automatic model_key(input logic [3:0] code, input logic modo,
                             output logic e_d, output logic e_m, output logic e_e);
        e_d = 1'b0; e_m = 1'b0; e_e = 1'b0;
        if (!modo) begin
            if (code <= 4'd9) begin
                m_digito = code;
                e_d = 1'b1;
            end
        end else if (code <= 4'd9) begin
            if (m_cnt < MAXD) begin
                m_acc = m_acc * 32'd10 + 32'(code);
                m_cnt++;
            end else e_e = 1'b1;
        end else if (code == 4'hB) begin
            m_acc = '0; m_cnt = 0;
        end else if (code == 4'hA) begin
            if (m_cnt > 0) begin
                m_monto = m_acc; e_m = 1'b1; m_acc = '0; m_cnt = 0;
            end else e_e = 1'b1;
        end
    endtask

    // One clean press: key sampled at edges 0..hold-1, released for gap edges.
    // toggle_at >= 0 flips MODO_MONTO just after edge toggle_at.
    task automatic press(input logic [3:0] code, input int hold, input int gap, input int toggle_at);
        logic e_d, e_m, e_e, do_act;
        do_act = 1'b1;
        if (toggle_at >= 0 && toggle_at <= D - 1) begin
            m_acc = '0; m_cnt = 0; m_modo = ~m_modo;
            if (toggle_at == D - 1) do_act = 1'b0;
        end
        e_d = 1'b0; e_m = 1'b0; e_e = 1'b0;
        if (do_act) model_key(code, m_modo, e_d, e_m, e_e);
        @(posedge CLK); #1;
        kp.KEY_CODE  = code;
        kp.KEY_VALID = 1'b1;
        for (int k = 0; k < hold + gap; k++) begin
            @(posedge CLK); #1;
            check("digito_stb", 32'(kp.DIGITO_STB), 32'((k == D) && e_d));
            check("monto_stb", 32'(kp.MONTO_STB), 32'((k == D) && e_m));
            check("error_tecla", 32'(kp.ERROR_TECLA), 32'((k == D) && e_e));
            if (k == D) begin
                check("digito", 32'(kp.DIGITO), 32'(m_digito));
                check("monto", kp.MONTO, m_monto);
                check("parcial", kp.MONTO_PARCIAL, m_acc);
                check("digitos_cnt", 32'(kp.DIGITOS_CNT), 32'(m_cnt));
            end
            if (k == hold - 1) kp.KEY_VALID = 1'b0;
            if (k == toggle_at) kp.MODO_MONTO = ~kp.MODO_MONTO;
        end
        if (toggle_at > D - 1) begin
            m_acc = '0; m_cnt = 0; m_modo = ~m_modo;
        end
        check("parcial_end", kp.MONTO_PARCIAL, m_acc);
        check("cnt_end", 32'(kp.DIGITOS_CNT), 32'(m_cnt));
        $display("press code=%0h modo=%0b toggle_at=%0d -> parcial=%0d cnt=%0d monto=%0d digito=%0d",
                 code, m_modo, toggle_at, kp.MONTO_PARCIAL, kp.DIGITOS_CNT, kp.MONTO, kp.DIGITO);
    endtask

    // Arbitrary KEY_VALID level pattern (bit k drives sample k), then idle
    task automatic levels(input logic [3:0] code, input logic [15:0] pat, input int n, input int exp_stb);
        int seen;
        seen = 0;
        @(posedge CLK); #1;
        kp.KEY_CODE = code;
        for (int k = 0; k < n + 2 * D + 4; k++) begin
            kp.KEY_VALID = (k < n) ? pat[k] : 1'b0;
            @(posedge CLK); #1;
            if (kp.DIGITO_STB) seen++;
        end
        check("bounce_strobes", 32'(seen), 32'(exp_stb));
        if (exp_stb > 0) m_digito = code;
        check("bounce_digito", 32'(kp.DIGITO), 32'(m_digito));
        $display("levels code=%0h n=%0d -> strobes=%0d", code, n, seen);
    endtask

    task automatic toggle_mode();
        @(posedge CLK); #1;
        kp.MODO_MONTO = ~kp.MODO_MONTO;
        m_modo = ~m_modo; m_acc = '0; m_cnt = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("toggle_parcial", kp.MONTO_PARCIAL, 32'd0);
        check("toggle_cnt", 32'(kp.DIGITOS_CNT), 32'd0);
        $display("mode -> %0b parcial=%0d cnt=%0d", m_modo, kp.MONTO_PARCIAL, kp.DIGITOS_CNT);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] amt1 [5];
        logic [3:0] amt2 [8];
        logic [3:0] code;
        int         tsel, tog;

        kp.KEY_VALID  = 1'b0;
        kp.KEY_CODE   = 4'h0;
        kp.MODO_MONTO = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_all_zero("post_reset");
        $display("reset released, outputs zero");

        // PIN digits 1..4
        for (int i = 1; i <= 4; i++) press(4'(i), 6, 6, -1);

        // Bounce 2 high / 1 low / 6 high, then a 3-cycle glitch
        levels(4'd5, 16'h01FB, 9, 1);
        levels(4'd6, 16'h0007, 3, 0);

        toggle_mode();
        amt1 = '{4'd3, 4'd0, 4'd0, 4'd0, 4'hA};
        foreach (amt1[i]) press(amt1[i], 6, 6, -1);
        check("monto_3000", kp.MONTO, 32'd3000);

        amt2 = '{4'd7, 4'd7, 4'hB, 4'd1, 4'd0, 4'd0, 4'd0, 4'hA};
        foreach (amt2[i]) press(amt2[i], 6, 6, -1);
        check("monto_1000", kp.MONTO, 32'd1000);
        press(4'hA, 6, 6, -1);
        check("monto_hold_1000", kp.MONTO, 32'd1000);

        for (int i = 0; i < 10; i++) press(4'd9, 6, 6, -1);
        press(4'hA, 6, 6, -1);
        check("monto_max", kp.MONTO, 32'd999999999);

        press(4'd4, 6, 6, -1);
        press(4'd2, 6, 6, -1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #2;
        check_all_zero("mid_reset");
        @(posedge CLK); #1;
        RESET = 1'b1;
        m_acc = '0; m_cnt = 0; m_monto = '0; m_digito = '0;
        repeat (2) @(posedge CLK);
        $display("reset pulse during amount entry");

        press(4'd4, 6, 6, -1);
        press(4'd2, 6, 6, -1);
        toggle_mode();

        // Randomized keys, timing and mode flips (including on the accept cycle)
        for (int i = 0; i < 60; i++) begin
            code = 4'($urandom_range(0, 13));
            tsel = $urandom_range(0, 7);
            tog  = (tsel == 0) ? D - 2 : (tsel == 1) ? D - 1 : (tsel == 2) ? D + 1 : -1;
            press(code, D + $urandom_range(0, 3), D + 2 + $urandom_range(0, 3), tog);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
